sweep_dual_ram: RTL and testbench

SWEEP_DUAL_RAM -- requirements
Module: sweep_dual_ram

---
 rtl/sweep_dual_ram.sv | 139 +++++++++++++
 tb/tb_sweep_dual_ram.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sweep_dual_ram.sv
// Single-clock RAM with one write port and one registered read port.
// After reset, or on request, a sweep writes INIT to every entry, one entry per cycle.
// While the sweep runs, busy is high and all user reads and writes are ignored.
// A read and a write to the same address on one edge resolve by BYPASS:
// 1 returns the new data, 0 returns the old contents.
module sweep_dual_ram #(
    parameter int               SIZE   = 8,
    parameter int               DEPTH  = 8,
    parameter logic [SIZE-1:0]  INIT   = '0,
    parameter bit               BYPASS = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(DEPTH)-1:0]  waddr,
    input  logic [SIZE-1:0]           write_data,
    input  logic                      write_en,
    input  logic [$clog2(DEPTH)-1:0]  raddr,
    input  logic                      read_en,
    input  logic                      clear,
    output logic [SIZE-1:0]           read_data,
    output logic                      read_valid,
    output logic                      busy
);

    localparam int              AW      = $clog2(DEPTH);
    // DEPTH is widened by one bit so addresses at or above a non-power-of-two depth compare correctly
    localparam logic [AW:0]     DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_L  = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [AW-1:0]      cnt_r;
    logic [AW-1:0]      cnt_s;
    logic [SIZE-1:0]    mem_r [DEPTH];

    logic               mem_we_s;
    logic [AW-1:0]      mem_addr_s;
    logic [SIZE-1:0]    mem_din_s;
    logic               rd_s;
    logic               rd_oob_s;
    logic               hit_s;

    logic [SIZE-1:0]    read_data_r;
    logic               read_valid_r;

    // State and sweep counter register; reset restarts the sweep at entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= CLEAR;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic and a single shared write port (the sweep and user writes never overlap)
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        mem_we_s   = 1'b0;
        mem_addr_s = cnt_r;
        mem_din_s  = INIT;
        rd_s       = 1'b0;
        case (state_r)
            CLEAR: begin
                if (clear) begin
                    cnt_s = '0;
                end else begin
                    mem_we_s = 1'b1;
                    if (cnt_r == LAST_L) begin
                        state_s = READY;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + AW'(1);
                    end
                end
            end
            READY: begin
                if (clear) begin
                    state_s = CLEAR;
                    cnt_s   = '0;
                end else begin
                    mem_we_s   = write_en && ({1'b0, waddr} < DEPTH_L);
                    mem_addr_s = waddr;
                    mem_din_s  = write_data;
                    rd_s       = read_en;
                end
            end
            default: begin
                state_s = CLEAR;
                cnt_s   = '0;
            end
        endcase
    end

    // Out-of-range reads return INIT; a same-address write counts only when it is a real READY write
    always_comb begin
        rd_oob_s = ({1'b0, raddr} >= DEPTH_L);
        hit_s    = (state_r == READY) && mem_we_s && (waddr == raddr);
    end

    // RAM array write; no reset here so the array maps onto block RAM, and the sweep does the clearing
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_r[mem_addr_s] <= mem_din_s;
        end
    end

    // Registered read port. The array is read before this edge's write lands (read-first);
    // with BYPASS set, the bypass mux substitutes the incoming data instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_r  <= INIT;
            read_valid_r <= 1'b0;
        end else begin
            read_valid_r <= rd_s;
            if (rd_s) begin
                if (rd_oob_s) begin
                    read_data_r <= INIT;
                end else if (BYPASS && hit_s) begin
                    read_data_r <= write_data;
                end else begin
                    read_data_r <= mem_r[raddr];
                end
            end
        end
    end

    assign read_data  = read_data_r;
    assign read_valid = read_valid_r;
    assign busy       = (state_r == CLEAR);

endmodule

// File: tb/tb_sweep_dual_ram.sv
// Testbench for sweep_dual_ram. Three instances share one set of inputs:
//   a: write-first, DEPTH 8, INIT A5
//   b: read-first,  DEPTH 8, INIT A5
//   c: write-first, DEPTH 6, INIT 5A
// Expected read results are queued per instance when a step is driven and
// compared after the clock edge.
module tb_sweep_dual_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] waddr;
    logic [7:0] write_data;
    logic       write_en;
    logic [2:0] raddr;
    logic       read_en;
    logic       clear;

    logic [7:0] rd_a, rd_b, rd_c;
    logic       rv_a, rv_b, rv_c;
    logic       busy_a, busy_b, busy_c;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;

    sweep_dual_ram #(.SIZE(8), .DEPTH(8), .INIT(8'hA5), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .waddr(waddr), .write_data(write_data), .write_en(write_en),
        .raddr(raddr), .read_en(read_en), .clear(clear),
        .read_data(rd_a), .read_valid(rv_a), .busy(busy_a)
    );

    sweep_dual_ram #(.SIZE(8), .DEPTH(8), .INIT(8'hA5), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .waddr(waddr), .write_data(write_data), .write_en(write_en),
        .raddr(raddr), .read_en(read_en), .clear(clear),
        .read_data(rd_b), .read_valid(rv_b), .busy(busy_b)
    );

    sweep_dual_ram #(.SIZE(8), .DEPTH(6), .INIT(8'h5A), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .waddr(waddr), .write_data(write_data), .write_en(write_en),
        .raddr(raddr), .read_en(read_en), .clear(clear),
        .read_data(rd_c), .read_valid(rv_c), .busy(busy_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic re, input logic [2:0] ra, input logic clr);
        write_en   = we;
        waddr      = wa;
        write_data = wd;
        read_en    = re;
        raddr      = ra;
        clear      = clr;
    endtask

    task automatic pop_chk(input string tag, inout exp_t q[$], input logic v, input logic [7:0] d);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk({tag, "_valid"}, {31'd0, v}, {31'd0, e.v});
            chk({tag, "_data"},  {24'd0, d}, {24'd0, e.d});
        end
    endtask

    // One clocked step: drive inputs, queue the expected outputs, then compare after the edge
    task automatic step(input string tag,
                        input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic re, input logic [2:0] ra, input logic clr,
                        input logic va, input logic [7:0] da,
                        input logic vb, input logic [7:0] db,
                        input logic vc, input logic [7:0] dc);
        drive(we, wa, wd, re, ra, clr);
        q_a.push_back('{v: va, d: da});
        q_b.push_back('{v: vb, d: db});
        q_c.push_back('{v: vc, d: dc});
        @(posedge clk);
        #1;
        pop_chk({tag, "_a"}, q_a, rv_a, rd_a);
        pop_chk({tag, "_b"}, q_b, rv_b, rd_b);
        pop_chk({tag, "_c"}, q_c, rv_c, rd_c);
    endtask

    // Count edges until busy falls in each instance. Outputs must stay quiet and held throughout;
    // with poke set, reads and writes are requested on the first five edges (all instances busy).
    task automatic sweep_len(input string tag, input logic poke,
                             input logic [7:0] ha, input logic [7:0] hb, input logic [7:0] hc);
        int fa = 0;
        int fb = 0;
        int fc = 0;
        for (int i = 1; i <= 20; i++) begin
            if (poke && i <= 5) drive(1'b1, 3'd1, 8'hFF, 1'b1, 3'd1, 1'b0);
            else                drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
            @(posedge clk);
            #1;
            chk({tag, "_rv_a"}, {31'd0, rv_a}, 32'd0);
            chk({tag, "_rv_b"}, {31'd0, rv_b}, 32'd0);
            chk({tag, "_rv_c"}, {31'd0, rv_c}, 32'd0);
            chk({tag, "_hold_a"}, {24'd0, rd_a}, {24'd0, ha});
            chk({tag, "_hold_b"}, {24'd0, rd_b}, {24'd0, hb});
            chk({tag, "_hold_c"}, {24'd0, rd_c}, {24'd0, hc});
            if (!busy_a && fa == 0) fa = i;
            if (!busy_b && fb == 0) fb = i;
            if (!busy_c && fc == 0) fc = i;
        end
        chk({tag, "_len_a"}, fa, 32'd8);
        chk({tag, "_len_b"}, fb, 32'd8);
        chk({tag, "_len_c"}, fc, 32'd6);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        // Reset state
        chk("rst_busy_a", {31'd0, busy_a}, 32'd1);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd1);
        chk("rst_busy_c", {31'd0, busy_c}, 32'd1);
        chk("rst_rv_a", {31'd0, rv_a}, 32'd0);
        chk("rst_rd_a", {24'd0, rd_a}, 32'hA5);
        chk("rst_rd_b", {24'd0, rd_b}, 32'hA5);
        chk("rst_rd_c", {24'd0, rd_c}, 32'h5A);
        rst = 1'b0;
        sweep_len("init_sweep", 1'b0, 8'hA5, 8'hA5, 8'h5A);

        // Every entry reads back INIT; addresses 6 and 7 are out of range for c and return its INIT
        for (int i = 0; i < 8; i++) begin
            step("rd_init", 1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b0,
                 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 8'h5A);
        end

        // Write then read back, then idle holds the data
        step("wr5",    1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, 8'h5A);
        step("rd5",    1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1, 8'h3C);
        step("hold5",  1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0, 8'h3C);

        // Same-address collision: write-first returns the new data, read-first returns the old
        step("wr2",    1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0, 8'h3C);
        step("coll2",  1'b1, 3'd2, 8'h77, 1'b1, 3'd2, 1'b0, 1'b1, 8'h77, 1'b1, 8'h11, 1'b1, 8'h77);
        step("rd2",    1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b1, 8'h77, 1'b1, 8'h77, 1'b1, 8'h77);

        // Read and write to different addresses on the same edge
        step("wr3rd5", 1'b1, 3'd3, 8'h42, 1'b1, 3'd5, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1, 8'h3C);
        step("rd3",    1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b1, 8'h42, 1'b1, 8'h42, 1'b1, 8'h42);

        // Address 7: in range for a/b, out of range for c (write dropped, read returns INIT)
        step("wr7",    1'b1, 3'd7, 8'hEE, 1'b0, 3'd0, 1'b0, 1'b0, 8'h42, 1'b0, 8'h42, 1'b0, 8'h42);
        step("coll7",  1'b1, 3'd7, 8'hDD, 1'b1, 3'd7, 1'b0, 1'b1, 8'hDD, 1'b1, 8'hEE, 1'b1, 8'h5A);
        step("rd7",    1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b0, 1'b1, 8'hDD, 1'b1, 8'hDD, 1'b1, 8'h5A);

        // Clear wins over a simultaneous write and read; requests during the sweep are ignored
        step("clr_wr", 1'b1, 3'd1, 8'hFF, 1'b1, 3'd1, 1'b1, 1'b0, 8'hDD, 1'b0, 8'hDD, 1'b0, 8'h5A);
        chk("clr_busy_a", {31'd0, busy_a}, 32'd1);
        chk("clr_busy_c", {31'd0, busy_c}, 32'd1);
        sweep_len("clr_sweep", 1'b1, 8'hDD, 8'hDD, 8'h5A);
        step("rd1",    1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 8'h5A);
        step("rd7clr", 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 8'h5A);

        // Reset in the middle of a sweep restarts it from entry 0
        step("clr2",   1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            step("mid",  1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, 8'h5A);
        end
        rst = 1'b1;
        step("midrst", 1'b1, 3'd2, 8'h99, 1'b1, 3'd2, 1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, 8'h5A);
        chk("midrst_busy_c", {31'd0, busy_c}, 32'd1);
        rst = 1'b0;
        sweep_len("rst_sweep", 1'b0, 8'hA5, 8'hA5, 8'h5A);
        step("rd2fin", 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 8'h5A);
        step("rd5fin", 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
